waveform_bram_interface: RTL and testbench
==========================================

Name: waveform_bram_interface

Overview:
- Loads a waveform of WORD_AMNT+1 words (WORD_WID bits each) from main RAM into an internal block RAM, using a simple DMA read handshake.
- Streams the loaded words sequentially to the autoapproach/waveform consumer.
- Sits between the SoC DMA port and the waveform generator.
- Each waveform word occupies two consecutive RAM words: low half first, then high half.

Parameters:
- WORD_WID, 20: width of one waveform word.
- WORD_AMNT_WID, 11: width of the word index.
- WORD_AMNT, 2047: index of the last word; the buffer holds WORD_AMNT+1 words.
- RAM_WID, 32: DMA address width.
- RAM_WORD_WID, 16: width of one RAM read.
- RAM_WORD_INCR, 2: address increment between consecutive RAM words.

Ports:
- clk, input, 1: system clock.
- rst_L, input, 1: asynchronous active-low reset.
- word, output, WORD_WID: word at the current read index.
- word_next, input, 1: advance the read index.
- word_last, output, 1: current index == WORD_AMNT.
- word_ok, output, 1: word is valid.
- word_rst, input, 1: return the read index to 0.
- refresh_start, input, 1: request a reload from RAM.
- start_addr, input, RAM_WID: RAM address of word 0 (low half).
- refresh_finished, output, 1: reload complete (level handshake).
- ram_dma_addr, output, RAM_WID: DMA read address.
- ram_word, input, RAM_WORD_WID: DMA read data.
- ram_read, output, 1: DMA read request.
- ram_valid, input, 1: DMA data valid.

Behaviour:
- Reset (rst_L low, asynchronous):
  - word, word_last, word_ok, refresh_finished, ram_read = 0; ram_dma_addr = 0.
  - Read index = 0; refresh FSM in IDLE; BRAM contents undefined.
- Refresh FSM: IDLE -> REQ_LO -> WAIT_LO -> REQ_HI -> WAIT_HI -> (next word or DONE) -> IDLE.
  - IDLE: on refresh_start=1, latch start_addr, set write index 0, drop word_ok, go REQ_LO.
  - REQ: drive ram_dma_addr and hold ram_read=1 until a cycle with ram_valid=1. In that cycle capture ram_word and drop ram_read the next cycle.
  - WAIT: wait for ram_valid=0 before issuing the next request.
  - Address sequence: start_addr + k*RAM_WORD_INCR, for k = 0 .. 2*(WORD_AMNT+1)-1, ascending, no gaps.
  - Word i assembly: bits [RAM_WORD_WID-1:0] come from the read at k=2i. Bits [WORD_WID-1:RAM_WORD_WID] come from bits [WORD_WID-RAM_WORD_WID-1:0] of the read at k=2i+1; the remaining high-read bits are ignored.
  - The assembled word is written to BRAM[i] once the high half is captured.
  - After word WORD_AMNT is written, go DONE.
  - DONE: refresh_finished=1 and held while refresh_start=1. When refresh_start=0, refresh_finished=0 the next cycle and the FSM returns to IDLE.
  - refresh_start must stay high throughout. Deasserting it mid-refresh does not abort; the refresh completes and DONE immediately releases.
- Read side:
  - BRAM read latency is 1 cycle.
  - After a refresh completes, the read index is 0 and word_ok rises 1 cycle after DONE is entered.
  - word_next with word_ok=1 and index < WORD_AMNT: index increments and word_ok=0 for exactly one cycle. On the following cycle word = new entry and word_ok=1.
  - word_next at index == WORD_AMNT: ignored; word, word_last and word_ok hold.
  - word_next with word_ok=0: ignored.
  - word_rst: index = 0, word_ok=0 for one cycle, then word = BRAM[0] with word_ok=1. word_rst beats a simultaneous word_next.
  - word_ok stays 0 from reset until the first refresh completes. It is also 0 for the whole of any refresh.
  - word_last = word_ok && (index == WORD_AMNT).
- Arithmetic: address arithmetic is modulo 2^RAM_WID; index arithmetic is WORD_AMNT_WID bits.

Test Plan:
- Fill RAM at 0x12340 with word i = 0x01000 + i (low 16 bits at 0x12340+4i, high 4 bits at 0x12342+4i); run a refresh with DMA latency 12 -> refresh_finished=1. Clear refresh_start -> refresh_finished=0 the next cycle, word_ok=1, word=0x01000.
- Step word_next 2047 times, waiting for word_ok each time -> word=0x01000+i at each step; word_last=1 only at i=2047 (word=0x017FF). One extra word_next -> no change.
- Set the high RAM word to 0xFFFA -> word[19:16]=0xA, upper bits ignored.
- At index 500, assert word_rst with word_next together -> word_ok=0 for one cycle, then word=0x01000 and word_last=0.
- Start a second refresh with different data at index 10 -> word_ok=0 during the refresh; afterwards index 0 shows the new data.
- Assert rst_L=0 mid-refresh -> ram_read and refresh_finished drop immediately; a new refresh after reset reloads correctly.

Source files
------------

// File: rtl/waveform_bram_interface.sv
// waveform_bram_interface
//
// Loads a waveform of WORD_AMNT+1 words from main RAM into a local block RAM
// through a simple request/valid DMA handshake. It then plays the words back
// one at a time to the waveform consumer. Each waveform word is stored in RAM
// as two consecutive RAM words: the low half first, then the high half.
//
// Ports:
//   clk, rst_L        system clock, asynchronous active-low reset
//   word              waveform word at the current read index
//   word_next         advance the read index (honoured only while word_ok)
//   word_last         word_ok and the read index is the last entry
//   word_ok           word holds valid data for the current index
//   word_rst          return the read index to 0 (wins over word_next)
//   refresh_start     level request to reload the buffer from RAM
//   start_addr        RAM address of the low half of word 0
//   refresh_finished  reload complete; held until refresh_start drops
//   ram_dma_addr      DMA read address
//   ram_word          DMA read data
//   ram_read          DMA read request
//   ram_valid         DMA read data valid
module waveform_bram_interface #(
    parameter int WORD_WID      = 20,
    parameter int WORD_AMNT_WID = 11,
    parameter int WORD_AMNT     = 2047,
    parameter int RAM_WID       = 32,
    parameter int RAM_WORD_WID  = 16,
    parameter int RAM_WORD_INCR = 2
) (
    input  logic                    clk,
    input  logic                    rst_L,
    output logic [WORD_WID-1:0]     word,
    input  logic                    word_next,
    output logic                    word_last,
    output logic                    word_ok,
    input  logic                    word_rst,
    input  logic                    refresh_start,
    input  logic [RAM_WID-1:0]      start_addr,
    output logic                    refresh_finished,
    output logic [RAM_WID-1:0]      ram_dma_addr,
    input  logic [RAM_WORD_WID-1:0] ram_word,
    output logic                    ram_read,
    input  logic                    ram_valid
);

    localparam int                     HI_W     = WORD_WID - RAM_WORD_WID;
    localparam logic [RAM_WID-1:0]     INCR     = RAM_WID'(RAM_WORD_INCR);
    localparam logic [WORD_AMNT_WID-1:0] LAST_IDX = WORD_AMNT_WID'(WORD_AMNT);

    typedef enum logic [2:0] {
        IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE
    } state_t;

    state_t                    state;
    logic [RAM_WORD_WID-1:0]   lo_half;
    logic [WORD_AMNT_WID-1:0]  wr_idx;
    logic [WORD_AMNT_WID-1:0]  rd_idx;
    logic                      rd_pend;
    logic                      loaded;
    logic                      bram_we;
    logic [WORD_WID-1:0]       bram_wdata;
    logic                      refreshing;
    logic                      finish_now;

    logic [WORD_WID-1:0] bram [0:WORD_AMNT];

    // The high RAM read only contributes its low HI_W bits; the rest is padding.
    assign bram_we    = (state == REQ_HI) && ram_valid;
    assign bram_wdata = {ram_word[HI_W-1:0], lo_half};

    // Anything from the accepted start request up to (not including) DONE
    // invalidates the read side.
    assign refreshing = ((state == IDLE) && refresh_start) ||
                        ((state != IDLE) && (state != DONE));
    assign finish_now = (state == WAIT_HI) && !ram_valid && (wr_idx == LAST_IDX);

    assign word_last  = word_ok && (rd_idx == LAST_IDX);

    // Refresh FSM: one request per RAM half, each followed by waiting for
    // ram_valid to fall so a lingering valid is never taken as new data.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state            <= IDLE;
            ram_dma_addr     <= '0;
            ram_read         <= 1'b0;
            refresh_finished <= 1'b0;
            wr_idx           <= '0;
            lo_half          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (refresh_start) begin
                        ram_dma_addr <= start_addr;
                        wr_idx       <= '0;
                        ram_read     <= 1'b1;
                        state        <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (ram_valid) begin
                        lo_half      <= ram_word;
                        ram_read     <= 1'b0;
                        ram_dma_addr <= ram_dma_addr + INCR;
                        state        <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!ram_valid) begin
                        ram_read <= 1'b1;
                        state    <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ram_valid) begin
                        ram_read     <= 1'b0;
                        ram_dma_addr <= ram_dma_addr + INCR;
                        state        <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (!ram_valid) begin
                        if (wr_idx == LAST_IDX) begin
                            refresh_finished <= 1'b1;
                            state            <= DONE;
                        end else begin
                            wr_idx   <= wr_idx + 1'b1;
                            ram_read <= 1'b1;
                            state    <= REQ_LO;
                        end
                    end
                end
                DONE: begin
                    if (!refresh_start) begin
                        refresh_finished <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Block RAM write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (bram_we) begin
            bram[wr_idx] <= bram_wdata;
        end
    end

    // Read side. rd_pend marks the single cycle in which the BRAM is read for
    // a new index; word_ok is low during that cycle and rises with the data.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            word    <= '0;
            word_ok <= 1'b0;
            rd_idx  <= '0;
            rd_pend <= 1'b0;
            loaded  <= 1'b0;
        end else if (refreshing) begin
            word_ok <= 1'b0;
            rd_idx  <= '0;
            rd_pend <= finish_now;
            loaded  <= loaded | finish_now;
        end else if (rd_pend) begin
            word    <= bram[rd_idx];
            word_ok <= 1'b1;
            rd_pend <= 1'b0;
        end else if (word_rst && loaded) begin
            rd_idx  <= '0;
            word_ok <= 1'b0;
            rd_pend <= 1'b1;
        end else if (word_next && word_ok && (rd_idx != LAST_IDX)) begin
            rd_idx  <= rd_idx + 1'b1;
            word_ok <= 1'b0;
            rd_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_waveform_bram_interface.sv
// Testbench for waveform_bram_interface with a 16-word buffer and a DMA
// responder of fixed latency backed by a computed RAM image.
module tb_waveform_bram_interface;

    localparam int N_LAST = 15;
    localparam int LAT    = 12;
    localparam int BUDGET = 3000;

    logic        clk = 1'b0;
    logic        rst_L;
    logic [19:0] word;
    logic        word_next, word_last, word_ok, word_rst;
    logic        refresh_start, refresh_finished;
    logic [31:0] start_addr, ram_dma_addr;
    logic [15:0] ram_word;
    logic        ram_read, ram_valid;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] dma_base = 32'h0;
    int          dma_set  = 0;
    int          dma_k    = 0;

    always #5 clk = ~clk;

    waveform_bram_interface #(
        .WORD_WID(20), .WORD_AMNT_WID(4), .WORD_AMNT(N_LAST),
        .RAM_WID(32), .RAM_WORD_WID(16), .RAM_WORD_INCR(2)
    ) dut (
        .clk(clk), .rst_L(rst_L), .word(word), .word_next(word_next),
        .word_last(word_last), .word_ok(word_ok), .word_rst(word_rst),
        .refresh_start(refresh_start), .start_addr(start_addr),
        .refresh_finished(refresh_finished), .ram_dma_addr(ram_dma_addr),
        .ram_word(ram_word), .ram_read(ram_read), .ram_valid(ram_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Set 0: word i = 0x01000+i except word 3, whose high RAM word is 0xFFFA.
    // Set 1: word i = 0x5A000+7*i. Padding bits of every high RAM word are set.
    function automatic logic [19:0] expw(input int set, input int i);
        if (set == 0) return (i == 3) ? 20'hA1003 : 20'(32'h01000 + i);
        return 20'(32'h5A000 + 7 * i);
    endfunction

    function automatic logic [15:0] mem(input logic [31:0] a);
        logic [31:0] k;
        logic [19:0] v;
        k = (a - dma_base) >> 1;
        v = expw(dma_set, int'(k >> 1));
        if (k[0]) return (dma_set == 0) ? {12'hFFF, v[19:16]} : {12'h123, v[19:16]};
        return v[15:0];
    endfunction

    // DMA responder: sees a request, checks its address, answers after LAT
    // cycles with a one-cycle valid pulse. A reset abandons the transfer.
    initial begin
        logic [31:0] a;
        ram_valid = 1'b0;
        ram_word  = 16'h0;
        forever begin
            @(negedge clk);
            if (rst_L === 1'b1 && ram_read === 1'b1) begin
                a = ram_dma_addr;
                chk("dma_addr", a, dma_base + 32'(2 * dma_k));
                dma_k++;
                for (int c = 0; c < LAT; c++) begin
                    @(negedge clk);
                    if (!rst_L) break;
                end
                if (rst_L) begin
                    ram_word  = mem(a);
                    ram_valid = 1'b1;
                    @(negedge clk);
                    ram_valid = 1'b0;
                    ram_word  = 16'h0;
                end
            end
        end
    end

    task automatic run_refresh(input logic [31:0] base, input int set);
        bit saw_ok = 0;
        bit done   = 0;
        @(negedge clk);
        dma_base      = base;
        dma_set       = set;
        dma_k         = 0;
        start_addr    = base;
        refresh_start = 1'b1;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (word_ok) saw_ok = 1;
            if (refresh_finished) begin
                done = 1;
                break;
            end
        end
        chk("refresh_done", 32'(done), 32'd1);
        chk("ok_low_during_refresh", 32'(saw_ok), 32'd0);
        chk("dma_read_count", 32'(dma_k), 32'(2 * (N_LAST + 1)));
        repeat (3) @(negedge clk);
        chk("finished_held", 32'(refresh_finished), 32'd1);
        refresh_start = 1'b0;
        @(posedge clk); #1;
        chk("finished_release", 32'(refresh_finished), 32'd0);
        chk("ok_after_refresh", 32'(word_ok), 32'd1);
        chk("word0_after_refresh", 32'(word), 32'(expw(set, 0)));
        chk("last_after_refresh", 32'(word_last), 32'd0);
    endtask

    task automatic step(input int set, input int i);
        @(negedge clk); word_next = 1'b1;
        @(negedge clk); word_next = 1'b0;
        for (int c = 0; c < 4 && !word_ok; c++) @(negedge clk);
        chk("step_ok", 32'(word_ok), 32'd1);
        chk("step_word", 32'(word), 32'(expw(set, i)));
        chk("step_last", 32'(word_last), 32'(i == N_LAST));
    endtask

    task automatic verify_all(input int set);
        for (int i = 1; i <= N_LAST; i++) step(set, i);
        @(negedge clk); word_next = 1'b1;
        @(negedge clk); word_next = 1'b0;
        @(negedge clk);
        chk("past_end_word", 32'(word), 32'(expw(set, N_LAST)));
        chk("past_end_ok", 32'(word_ok), 32'd1);
        chk("past_end_last", 32'(word_last), 32'd1);
    endtask

    task automatic do_word_rst();
        @(negedge clk); word_rst = 1'b1;
        @(negedge clk); word_rst = 1'b0;
        @(negedge clk);
        chk("word_rst_word", 32'(word), 32'(expw(0, 0)) & 32'hFFFFF);
    endtask

    typedef struct {
        logic        nxt;
        logic        rst;
        logic        chk_word;
        logic [19:0] exp_word;
        logic        exp_ok;
        logic        exp_last;
    } vec_t;

    vec_t vecs [15];

    initial begin
        rst_L = 1'b0; word_next = 1'b0; word_rst = 1'b0;
        refresh_start = 1'b0; start_addr = 32'h0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 20'h01001, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 20'h01002, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 20'h01002, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 20'h01000, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 20'h01001, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 20'h01002, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 20'hA1003, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 20'h01000, 1'b1, 1'b0};

        #23;
        chk("rst_word", 32'(word), 32'd0);
        chk("rst_ok", 32'(word_ok), 32'd0);
        chk("rst_last", 32'(word_last), 32'd0);
        chk("rst_finished", 32'(refresh_finished), 32'd0);
        chk("rst_ram_read", 32'(ram_read), 32'd0);
        chk("rst_dma_addr", ram_dma_addr, 32'd0);
        @(negedge clk); rst_L = 1'b1;
        repeat (2) @(negedge clk);
        chk("ok_before_refresh", 32'(word_ok), 32'd0);

        run_refresh(32'h0001_2340, 0);

        foreach (vecs[v]) begin
            @(negedge clk);
            word_next = vecs[v].nxt;
            word_rst  = vecs[v].rst;
            @(posedge clk); #1;
            word_next = 1'b0;
            word_rst  = 1'b0;
            chk($sformatf("vec%0d_ok", v), 32'(word_ok), 32'(vecs[v].exp_ok));
            chk($sformatf("vec%0d_last", v), 32'(word_last), 32'(vecs[v].exp_last));
            if (vecs[v].chk_word)
                chk($sformatf("vec%0d_word", v), 32'(word), 32'(vecs[v].exp_word));
        end

        verify_all(0);

        do_word_rst();
        for (int i = 1; i <= 10; i++) step(0, i);
        run_refresh(32'h0002_0000, 1);
        verify_all(1);

        // Reset in the middle of a refresh.
        @(negedge clk);
        dma_base = 32'h0001_2340; dma_set = 0; dma_k = 0;
        start_addr = 32'h0001_2340;
        refresh_start = 1'b1;
        repeat (60) @(negedge clk);
        @(posedge clk); #3;
        rst_L = 1'b0;
        #1;
        chk("midrst_ram_read", 32'(ram_read), 32'd0);
        chk("midrst_finished", 32'(refresh_finished), 32'd0);
        chk("midrst_ok", 32'(word_ok), 32'd0);
        chk("midrst_dma_addr", ram_dma_addr, 32'd0);
        refresh_start = 1'b0;
        @(negedge clk); rst_L = 1'b1;
        run_refresh(32'h0001_2340, 0);
        verify_all(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
